// File: rtl/serializador_bits.sv
// Byte FIFO feeding an MSB-first bit serializer for the bit-serial word detector.
// Back-to-back bytes form one gap-free session opened by a single start pulse.
module serializador_bits #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_byte_in,
    input  logic                          i_byte_valid,
    output logic                          o_byte_ready,
    input  logic                          i_parar,
    output logic                          o_bit_out,
    output logic                          o_bit_valid,
    output logic                          o_start,
    output logic                          o_ocupado,
    output logic [$clog2(FIFO_DEPTH):0]   o_nivel
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] S_OCIOSO   = 1'b0;
    localparam logic [0:0] S_ENVIANDO = 1'b1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [0:0]    r_state;
    logic [7:0]    r_sh;
    logic [2:0]    r_cnt;
    logic          r_bit_out;
    logic          r_bit_valid;
    logic          r_start;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // Readiness comes from the registered count only: no bypass when full.
    assign o_byte_ready = !w_full && !i_parar && !i_rst;
    assign w_push       = i_byte_valid && o_byte_ready;

    // A byte is taken only when the shifter is idle or on its last bit.
    assign w_pop = !w_empty &&
                   ((r_state == S_OCIOSO) || (r_cnt == 3'd0));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_byte_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= S_OCIOSO;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_start     <= 1'b0;
        end else if (i_parar) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= S_OCIOSO;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_start     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            unique case (r_state)
                S_OCIOSO: begin
                    if (w_pop) begin
                        r_bit_out   <= w_head[7];
                        r_sh        <= {w_head[6:0], 1'b0};
                        r_cnt       <= 3'd7;
                        r_bit_valid <= 1'b1;
                        r_start     <= 1'b1;
                        r_state     <= S_ENVIANDO;
                    end
                end
                S_ENVIANDO: begin
                    if (r_cnt != 3'd0) begin
                        r_bit_out <= r_sh[7];
                        r_sh      <= {r_sh[6:0], 1'b0};
                        r_cnt     <= r_cnt - 3'd1;
                        r_start   <= 1'b0;
                    end else if (w_pop) begin
                        r_bit_out <= w_head[7];
                        r_sh      <= {w_head[6:0], 1'b0};
                        r_cnt     <= 3'd7;
                        r_start   <= 1'b0;
                    end else begin
                        r_bit_out   <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_start     <= 1'b0;
                        r_state     <= S_OCIOSO;
                    end
                end
                default: begin
                    r_state <= S_OCIOSO;
                end
            endcase
        end
    end

    assign o_bit_out   = r_bit_out;
    assign o_bit_valid = r_bit_valid;
    assign o_start     = r_start;
    assign o_ocupado   = (r_state == S_ENVIANDO);
    assign o_nivel     = r_count;

endmodule

// File: doc/serializador_bits.md
# serializador_bits

Upstream feeder for the bit-serial word detector. Accepts bytes through a valid/ready handshake into a small FIFO and shifts them out MSB-first, one bit per clock. Drives the detector's `bit_in`/`start` inputs. A detection session opens with a one-cycle `start` pulse coincident with the first bit. The session runs gap-free for as long as bytes are queued back-to-back.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `byte_in` in 8: byte to serialize.
- `byte_valid` in 1: `byte_in` valid.
- `byte_ready` out 1: FIFO can accept this cycle.
- `parar` in 1: synchronous abort/flush.
- `bit_out` out 1: serial bit to detector `bit_in`.
- `bit_valid` out 1: `bit_out` carries a real bit.
- `start` out 1: one-cycle pulse marking first bit of a session; to detector `start`.
- `ocupado` out 1: FSM in ENVIANDO.
- `nivel` out $clog2(FIFO_DEPTH)+1: FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Push occurs when `byte_valid && byte_ready` at a clock edge.
  - `byte_ready = !full && !parar && !rst` (combinational from registered count).
  - No bypass: a full FIFO stays not-ready even if a pop happens in the same cycle.
  - Push and pop in the same edge are allowed; `nivel` is unchanged in that case.
- FSM states: OCIOSO, ENVIANDO.
- Registered state: shift register `sh[7:0]` and remaining-bit counter `cnt[2:0]`.
- OCIOSO with FIFO non-empty at an edge:
  - Pop byte b.
  - `bit_out<=b[7]`, `sh<=b<<1`, `cnt<=7`, `bit_valid<=1`, `start<=1`.
  - Next state ENVIANDO.
- ENVIANDO with `cnt>0` at an edge:
  - `bit_out<=sh[7]`, `sh<=sh<<1`, `cnt<=cnt-1`, `start<=0`.
- ENVIANDO with `cnt==0` at an edge:
  - FIFO non-empty: pop next byte, load as above, but `start<=0`. The session continues with no bubble.
  - FIFO empty: `bit_valid<=0`, `start<=0`, `bit_out<=0`, go to OCIOSO. The session ends.
- The detector shifts every cycle, so a gap is never inserted inside a session. Any later byte opens a new session with a fresh `start`.
- `parar` at an edge:
  - FIFO emptied (`nivel<=0`).
  - `bit_valid`, `start`, `bit_out` go to 0; state goes to OCIOSO; any partial byte is discarded.
  - A push offered in that cycle is refused (`byte_ready=0`).
- Priority: `rst` > `parar` > normal operation.
- `ocupado` = (state==ENVIANDO). It equals `bit_valid`.
- Reset values: `bit_out=0`, `bit_valid=0`, `start=0`, `ocupado=0`, `nivel=0`; FIFO pointers 0; state OCIOSO; `byte_ready=0` while `rst` is high, 1 on the first cycle after.
- Reset mid-byte discards everything. No residual bits are emitted after reset.

## Timing
- All outputs except `byte_ready` are registered.
- Latency: byte pushed at edge E, popped at edge E+1.
  - `start=1` and `bit_out=b[7]` are visible from E+1 to E+2.
  - The detector samples the first bit at edge E+2.
- Bits b[7]..b[0] occupy 8 consecutive cycles.
- With continuous supply, throughput is 1 byte per 8 cycles. `byte_ready` stays high unless the FIFO is full.
- `start` is high for exactly one cycle per session, always with `bit_valid=1`.
- Pop happens only at the edge where a byte load occurs. `nivel` updates on the same edge.
- Abort: `parar` high at edge P gives `bit_valid=0` from P onward. A push in the next cycle is accepted normally.

## Test plan
- Single byte 0xA5 after reset:
  - One `start` pulse, coincident with the first bit.
  - `bit_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `bit_valid=1`.
  - Then `bit_valid=0` and `ocupado=0`.
- Bytes 0x12, 0x34 pushed on consecutive cycles:
  - 16 contiguous bits 0001001000110100.
  - Exactly one `start`.
  - `nivel` sequence 1,1,0 across the pushes and pops.
- Byte 0xFF, idle 20 cycles, then 0x00:
  - Two sessions, two `start` pulses.
  - `bit_valid` low during the gap.
- Push 6 bytes back-to-back with `FIFO_DEPTH=4`:
  - `byte_ready` drops when `nivel=4`.
  - The extra byte is held off until a pop.
  - All 6 bytes are emitted in order with no bubble and one `start`.
- `parar` asserted at bit 3 of 0xC3 with 2 bytes queued:
  - `bit_valid=0` next cycle, `nivel=0`.
  - A following push of 0x81 produces a new `start` and 10000001.
- `rst` pulsed mid-byte:
  - All outputs reach reset values on the next edge.
  - No further bits until a new push.
